// File: rtl/fracnet_t_div_seq.sv
// Sequential signed-by-unsigned divider for de-scaling 24-bit scaled values back
// to the 16-bit feature format. Radix-2 restoring division on the dividend
// magnitude, one quotient bit per cycle, with sign fix-up and saturation applied
// in a final cycle. Latency is fixed at 26 edges from acceptance to out_valid,
// including for divide-by-zero.
module fracnet_t_div_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 24,
  parameter int unsigned DIVISOR_WIDTH  = 9,
  parameter int unsigned QUOTIENT_WIDTH = 16
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic        [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH:0]    remainder,
  output logic                             ovf,
  output logic                             dbz
);

  localparam int unsigned DW   = DIVIDEND_WIDTH;
  localparam int unsigned SW   = DIVISOR_WIDTH;
  localparam int unsigned QW   = QUOTIENT_WIDTH;
  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CntW-1:0] CountInit = CntW'(DW - 1);

  // Saturated quotient values.
  localparam logic signed [QW-1:0] QPos = {1'b0, {(QW-1){1'b1}}};
  localparam logic signed [QW-1:0] QNeg = {1'b1, {(QW-1){1'b0}}};

  // Largest representable quotient magnitudes for each sign.
  localparam logic [DW-1:0] QMagMaxPos = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic [DW-1:0] QMagMaxNeg = {{(DW-QW){1'b0}}, 1'b1, {(QW-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operation context, latched on acceptance.
  logic            sign_q, sign_d;
  logic            op_dbz_q, op_dbz_d;
  logic [SW-1:0]   div_q, div_d;

  // Iteration state.
  logic [CntW-1:0] count_q, count_d;
  logic [DW-1:0]   mag_q, mag_d;
  logic [SW-1:0]   prem_q, prem_d;
  logic [DW-1:0]   quot_q, quot_d;

  // Registered results, held from one FIX to the next.
  logic signed [QW-1:0] quotient_q, quotient_d;
  logic signed [SW:0]   remainder_q, remainder_d;
  logic                 ovf_q, ovf_d;
  logic                 dbz_q, dbz_d;

  // Datapath intermediates.
  logic [DW-1:0]        dividend_mag;
  logic [SW:0]          shifted;
  logic [SW-1:0]        diff;
  logic                 fits;
  logic                 qbit;
  logic                 sat_pos;
  logic                 sat_neg;
  logic signed [QW-1:0] q_neg;
  logic [SW:0]          rem_ext;
  logic [SW:0]          rem_neg;

  // Dividend magnitude and one restoring-division step.
  always_comb begin
    // -2^(DW-1) maps to 2^(DW-1), which still fits the unsigned magnitude.
    dividend_mag = dividend[DW-1] ? -dividend : dividend;
    shifted      = {prem_q, mag_q[DW-1]};
    fits         = shifted >= {1'b0, div_q};
    // When fits is set the true difference is below the divisor, so the low
    // SW bits of the subtraction are exact.
    diff         = shifted[SW-1:0] - div_q;
    qbit         = fits & ~op_dbz_q;
  end

  // Sign application and saturation inputs for the FIX cycle.
  always_comb begin
    sat_pos = quot_q > QMagMaxPos;
    sat_neg = quot_q > QMagMaxNeg;
    q_neg   = -quot_q[QW-1:0];
    rem_ext = {1'b0, prem_q};
    rem_neg = -rem_ext;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    op_dbz_d    = op_dbz_q;
    div_d       = div_q;
    count_d     = count_q;
    mag_d       = mag_q;
    prem_d      = prem_q;
    quot_d      = quot_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d   = dividend[DW-1];
          mag_d    = dividend_mag;
          div_d    = divisor;
          op_dbz_d = (divisor == '0);
          prem_d   = '0;
          quot_d   = '0;
          count_d  = CountInit;
          state_d  = StCalc;
        end
      end

      StCalc: begin
        // A failed trial leaves shifted below the divisor, so it fits SW bits.
        // Under divide-by-zero the partial remainder is discarded anyway.
        prem_d = qbit ? diff : shifted[SW-1:0];
        quot_d = {quot_q[DW-2:0], qbit};
        mag_d  = {mag_q[DW-2:0], 1'b0};
        if (count_q == '0) begin
          state_d = StFix;
        end else begin
          count_d = count_q - CntW'(1);
        end
      end

      StFix: begin
        dbz_d = op_dbz_q;
        if (op_dbz_q) begin
          ovf_d       = 1'b1;
          remainder_d = '0;
          quotient_d  = sign_q ? QNeg : QPos;
        end else if (!sign_q) begin
          remainder_d = rem_ext;
          if (sat_pos) begin
            quotient_d = QPos;
            ovf_d      = 1'b1;
          end else begin
            quotient_d = quot_q[QW-1:0];
            ovf_d      = 1'b0;
          end
        end else begin
          remainder_d = rem_neg;
          if (sat_neg) begin
            quotient_d = QNeg;
            ovf_d      = 1'b1;
          end else begin
            // A zero magnitude negates to zero, so -0 never appears.
            quotient_d = q_neg;
            ovf_d      = 1'b0;
          end
        end
        state_d = StDone;
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      sign_q      <= 1'b0;
      op_dbz_q    <= 1'b0;
      div_q       <= '0;
      count_q     <= '0;
      mag_q       <= '0;
      prem_q      <= '0;
      quot_q      <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      op_dbz_q    <= op_dbz_d;
      div_q       <= div_d;
      count_q     <= count_d;
      mag_q       <= mag_d;
      prem_q      <= prem_d;
      quot_q      <= quot_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  // Handshake flags decode directly from the state; results come from registers.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    quotient  = quotient_q;
    remainder = remainder_q;
    ovf       = ovf_q;
    dbz       = dbz_q;
  end

endmodule
